ev_charge_session_ctrl: RTL and testbench
=========================================

Name: ev_charge_session_ctrl

Overview:
Sits directly downstream of the EV-CS authentication stage. It consumes that stage's mutual-authentication flag and session key, and runs one charging session per request. The session proceeds as gated charge enable, then metered energy accumulation with a cap, then a keyed billing record handed to the USP side over a valid/ready handshake. Faults, authentication loss and timeouts force a safe stop.

Parameters:
ENERGY_W, 32, width of accumulated energy counter (Wh)
MAX_ENERGY, 32'h0001_0000, session energy cap in Wh; reaching it ends charging
AUTH_TIMEOUT, 1024, cycles allowed in AUTH_WAIT before timeout fault
METER_TIMEOUT, 4096, watchdog window in CHARGING (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start_req  in  1  one-cycle pulse: open session
stop_req  in  1  one-cycle pulse: user stop
tariff  in  16  price per Wh, latched on accepted start_req
auth_ok  in  1  level from mutual_authentication_established
session_key  in  64  session key from authentication stage, latched on auth_ok
cs_id  in  64  charging-station identity, latched on accepted start_req
meter_valid  in  1  energy sample strobe
meter_wh  in  16  energy increment for this sample
fault  in  1  external hardware fault (level)
fault_clr  in  1  pulse: leave FAULT
charge_en  out  1  contactor enable
energy_total  out  ENERGY_W  accumulated energy of current/last session
state  out  3  FSM state encoding
bill_valid  out  1  billing record valid
bill_ready  in  1  downstream accepts record
bill_amount  out  48  energy_total * tariff
bill_tag  out  64  session_key ^ cs_id ^ {16'd0, bill_amount}
session_done  out  1  one-cycle pulse after bill handshake
timeout_err  out  1  sticky until fault_clr; set on any timeout
fault_flag  out  1  high while in FAULT

Behaviour:
- Reset: state=IDLE; all outputs 0; internal key/tariff/cs_id/timer registers 0. Reset mid-session drops charge_en immediately (async) and discards the session.
- Encodings: IDLE=0, AUTH_WAIT=1, CHARGING=2, STOPPING=3, BILLING=4, FAULT=5.
- Global priority each cycle: fault (any state except IDLE) > auth_ok loss > stop_req/cap > meter accumulate.
- IDLE: on start_req, latch tariff and cs_id, clear energy_total and timer, go to AUTH_WAIT. Other inputs are ignored.
- AUTH_WAIT:
  - auth_ok=1: latch session_key, go to CHARGING (charge_en=1 from the next cycle).
  - stop_req: go to IDLE, no bill.
  - Timer counts each cycle; at AUTH_TIMEOUT-1 without auth_ok, go to FAULT and set timeout_err.
  - auth_ok and timeout in the same cycle: auth_ok wins.
- CHARGING:
  - charge_en=1.
  - meter_valid: energy_total <= min(energy_total + meter_wh, MAX_ENERGY), computed at ENERGY_W+1 bits and saturating.
  - A sample in the same cycle as stop_req is still accumulated.
  - Result >= MAX_ENERGY, or stop_req: go to STOPPING.
  - auth_ok=0 or fault: go to FAULT; the sample in that cycle is discarded.
- STOPPING: charge_en=0; compute bill_amount (unsigned 32x16, low 48 bits kept) and bill_tag in one cycle; go to BILLING.
- BILLING:
  - bill_valid=1, payload stable until bill_valid && bill_ready.
  - On handshake: bill_valid=0, session_done pulses next cycle, go to IDLE.
  - start_req is ignored. bill_ready while bill_valid=0 has no effect.
- FAULT:
  - charge_en=0, fault_flag=1, bill_valid=0.
  - fault_clr with fault=0: go to IDLE and clear timeout_err.
  - fault_clr while fault=1: ignored.
- energy_total holds its value in IDLE until the next start_req.

Optional Feature:
SESSION_WATCHDOG_EN
- Defined: in CHARGING, a meter timer counts cycles since the last meter_valid (reset on entry and on every sample). At METER_TIMEOUT-1 it goes to FAULT and sets timeout_err.
- Undefined: no watchdog logic; CHARGING persists indefinitely without samples. METER_TIMEOUT is unused.

Decomposition:
- Package ev_session_pkg holds:
  - state typedef and encodings;
  - BILL_AMT_W=48 and KEY_W=64;
  - the bill_tag construction function.
- One sub-module, session_timer: load/clear, enable, terminal-count compare against a parameter. It is instantiated for the auth timeout and, under the macro, for the meter watchdog.

Test Plan:
- Normal session: start_req with tariff=5 and cs_id=64'hDDDD_DDDD_DDDD_DDDD; auth_ok after 3 cycles; three samples of 100 Wh; stop_req; bill_ready held high. Expect energy_total=300, bill_amount=1500, bill_tag=key^cs_id^1500, session_done one cycle after handshake, state back to 0.
- Auth timeout: start_req, auth_ok held 0. Expect state=FAULT and timeout_err=1 exactly AUTH_TIMEOUT cycles after entering AUTH_WAIT; fault_clr returns to IDLE with timeout_err=0.
- Energy cap with MAX_ENERGY=1000: samples of 600 then 600. Expect energy_total=1000 (saturated), automatic STOPPING, charge_en=0.
- Auth drop / fault priority: in CHARGING, drop auth_ok in the same cycle as meter_valid=50 and stop_req. Expect FAULT, sample discarded, no bill_valid. Repeat with fault=1: FAULT entered, and fault_clr is ignored until fault=0.
- Bill back-pressure: bill_ready low for 10 cycles, with start_req pulsed meanwhile. Expect bill_valid and payload stable, start_req ignored, session_done only after bill_ready=1.
- Watchdog (SESSION_WATCHDOG_EN defined, METER_TIMEOUT=16): enter CHARGING, no samples. Expect FAULT and timeout_err after 16 cycles. With the macro undefined, expect CHARGING to persist.

Source files
------------

// File: rtl/ev_session_pkg.sv
// Purpose: shared types and helpers for the EV charging-session controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: session FSM state encoding, bill/key widths, bill record struct,
//           and the keyed bill-tag construction.
package ev_session_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_AUTH_WAIT = 3'd1,
        ST_CHARGING  = 3'd2,
        ST_STOPPING  = 3'd3,
        ST_BILLING   = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int BILL_AMT_W = 48;
    localparam int KEY_W      = 64;

    typedef struct packed {
        logic [BILL_AMT_W-1:0] amount;
        logic [KEY_W-1:0]      tag;
    } bill_t;

    // Tag binds the amount to this session's key and station identity.
    function automatic logic [KEY_W-1:0] make_bill_tag(
        input logic [KEY_W-1:0]      key,
        input logic [KEY_W-1:0]      id,
        input logic [BILL_AMT_W-1:0] amount
    );
        return key ^ id ^ {{(KEY_W-BILL_AMT_W){1'b0}}, amount};
    endfunction

endpackage

// File: rtl/session_timer.sv
// Purpose: cycle counter with synchronous clear and terminal-count flag.
// Latency: tc_hit is combinational from the count register.
// Backpressure: none; the count holds at terminal count until cleared.
// Ports: clk, rst (async high), clr (sync clear, wins over en),
//        en (count enable), tc_hit (count == TC-1).
module session_timer #(
    parameter int TC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_hit
);

    localparam int CW = (TC > 2) ? $clog2(TC) : 1;

    logic [CW-1:0] count;

    assign tc_hit = (count == CW'(TC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc_hit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ev_charge_session_ctrl.sv
// Purpose: one EV charging session per request: auth gate, metered charge, keyed bill.
// Latency: charge_en one cycle after auth_ok; bill presented two cycles after stop/cap.
// Backpressure: bill record held stable in BILLING until bill_valid && bill_ready.
// Ports: start_req/stop_req/tariff/cs_id (session control), auth_ok/session_key
//        (from authentication), meter_valid/meter_wh (energy samples), fault/fault_clr,
//        charge_en, energy_total, state, bill_valid/bill_ready/bill_amount/bill_tag,
//        session_done, timeout_err, fault_flag.
// Build option: SESSION_WATCHDOG_EN adds a meter-sample watchdog in CHARGING.
module ev_charge_session_ctrl
    import ev_session_pkg::*;
#(
    parameter int                  ENERGY_W      = 32,
    parameter logic [ENERGY_W-1:0] MAX_ENERGY    = 32'h0001_0000,
    parameter int                  AUTH_TIMEOUT  = 1024,
    parameter int                  METER_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_req,
    input  logic                  stop_req,
    input  logic [15:0]           tariff,
    input  logic                  auth_ok,
    input  logic [63:0]           session_key,
    input  logic [63:0]           cs_id,
    input  logic                  meter_valid,
    input  logic [15:0]           meter_wh,
    input  logic                  fault,
    input  logic                  fault_clr,
    output logic                  charge_en,
    output logic [ENERGY_W-1:0]   energy_total,
    output logic [2:0]            state,
    output logic                  bill_valid,
    input  logic                  bill_ready,
    output logic [47:0]           bill_amount,
    output logic [63:0]           bill_tag,
    output logic                  session_done,
    output logic                  timeout_err,
    output logic                  fault_flag
);

    state_t              state_q, state_nxt;
    logic [15:0]         tariff_q;
    logic [KEY_W-1:0]    key_q, cs_id_q;
    logic [ENERGY_W-1:0] energy_q;
    bill_t               bill_q;
    logic                done_q, tmo_q;
    logic                auth_tc, meter_tc, tmo_set;

    // Accumulate one bit wider so the sum cannot wrap before the cap compare.
    logic [ENERGY_W:0]     sum_c;
    logic                  cap_hit;
    logic [ENERGY_W-1:0]   energy_capped;
    logic [BILL_AMT_W-1:0] amount_c;

    assign sum_c         = {1'b0, energy_q} + (ENERGY_W+1)'(meter_wh);
    assign cap_hit       = (sum_c >= {1'b0, MAX_ENERGY});
    assign energy_capped = cap_hit ? MAX_ENERGY : sum_c[ENERGY_W-1:0];
    assign amount_c      = BILL_AMT_W'(energy_q) * BILL_AMT_W'(tariff_q);

    session_timer #(.TC(AUTH_TIMEOUT)) u_auth_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != ST_AUTH_WAIT),
        .en     (1'b1),
        .tc_hit (auth_tc)
    );

`ifdef SESSION_WATCHDOG_EN
    // Restarts on entry to CHARGING and on every meter sample.
    session_timer #(.TC(METER_TIMEOUT)) u_meter_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state_q != ST_CHARGING) || meter_valid),
        .en     (1'b1),
        .tc_hit (meter_tc)
    );
`else
    logic unused_meter_cfg;
    assign unused_meter_cfg = (METER_TIMEOUT != 0);
    assign meter_tc         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        tmo_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) state_nxt = ST_AUTH_WAIT;
            end
            ST_AUTH_WAIT: begin
                if (fault) begin
                    state_nxt = ST_FAULT;
                end else if (auth_ok) begin
                    state_nxt = ST_CHARGING;
                end else if (stop_req) begin
                    state_nxt = ST_IDLE;
                end else if (auth_tc) begin
                    state_nxt = ST_FAULT;
                    tmo_set   = 1'b1;
                end
            end
            ST_CHARGING: begin
                if (fault || !auth_ok) begin
                    state_nxt = ST_FAULT;
                end else if (meter_tc && !meter_valid) begin
                    state_nxt = ST_FAULT;
                    tmo_set   = 1'b1;
                end else if (stop_req || (meter_valid && cap_hit)) begin
                    state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                state_nxt = fault ? ST_FAULT : ST_BILLING;
            end
            ST_BILLING: begin
                if (fault)           state_nxt = ST_FAULT;
                else if (bill_ready) state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr && !fault) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tariff_q <= '0;
            cs_id_q  <= '0;
            key_q    <= '0;
            energy_q <= '0;
            bill_q   <= '0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            done_q <= (state_q == ST_BILLING) && (state_nxt == ST_IDLE);
            if (state_q == ST_IDLE && start_req) begin
                tariff_q <= tariff;
                cs_id_q  <= cs_id;
                energy_q <= '0;
            end
            if (state_q == ST_AUTH_WAIT && state_nxt == ST_CHARGING) begin
                key_q <= session_key;
            end
            // A sample coinciding with a fault or auth loss is dropped.
            if (state_q == ST_CHARGING && meter_valid && state_nxt != ST_FAULT) begin
                energy_q <= energy_capped;
            end
            if (state_q == ST_STOPPING) begin
                bill_q.amount <= amount_c;
                bill_q.tag    <= make_bill_tag(key_q, cs_id_q, amount_c);
            end
            if (tmo_set) begin
                tmo_q <= 1'b1;
            end else if (state_q == ST_FAULT && state_nxt == ST_IDLE) begin
                tmo_q <= 1'b0;
            end
        end
    end

    assign charge_en    = (state_q == ST_CHARGING);
    assign bill_valid   = (state_q == ST_BILLING);
    assign fault_flag   = (state_q == ST_FAULT);
    assign state        = state_q;
    assign energy_total = energy_q;
    assign bill_amount  = bill_q.amount;
    assign bill_tag     = bill_q.tag;
    assign session_done = done_q;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_ev_charge_session_ctrl.sv
// Purpose: directed self-checking bench for ev_charge_session_ctrl.
// Latency: n/a.
// Backpressure: exercises bill_ready held low with start_req pulsed during BILLING.
module tb_ev_charge_session_ctrl;

    localparam int AUTH_TO  = 20;
    localparam int METER_TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_req, stop_req, auth_ok, meter_valid, fault, fault_clr, bill_ready;
    logic [15:0] tariff, meter_wh;
    logic [63:0] session_key, cs_id;
    logic        charge_en, bill_valid, session_done, timeout_err, fault_flag;
    logic [31:0] energy_total;
    logic [2:0]  state;
    logic [47:0] bill_amount;
    logic [63:0] bill_tag;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] KEY = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CS  = 64'hDDDD_DDDD_DDDD_DDDD;

    ev_charge_session_ctrl #(
        .ENERGY_W      (32),
        .MAX_ENERGY    (32'd1000),
        .AUTH_TIMEOUT  (AUTH_TO),
        .METER_TIMEOUT (METER_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_req    (start_req),
        .stop_req     (stop_req),
        .tariff       (tariff),
        .auth_ok      (auth_ok),
        .session_key  (session_key),
        .cs_id        (cs_id),
        .meter_valid  (meter_valid),
        .meter_wh     (meter_wh),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .charge_en    (charge_en),
        .energy_total (energy_total),
        .state        (state),
        .bill_valid   (bill_valid),
        .bill_ready   (bill_ready),
        .bill_amount  (bill_amount),
        .bill_tag     (bill_tag),
        .session_done (session_done),
        .timeout_err  (timeout_err),
        .fault_flag   (fault_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse start_req with the given tariff/station, then raise auth_ok.
    task automatic open_session(input logic [15:0] t, input logic [63:0] id);
        tariff = t; cs_id = id; start_req = 1'b1;
        step(1);
        start_req = 1'b0;
        auth_ok = 1'b1; session_key = KEY;
        step(1);
    endtask

    initial begin
        rst = 1'b1;
        start_req = 0; stop_req = 0; auth_ok = 0; meter_valid = 0; fault = 0;
        fault_clr = 0; bill_ready = 0; tariff = 0; meter_wh = 0;
        session_key = 0; cs_id = 0;
        step(2);
        chk("rst_state", state, 0);
        chk("rst_charge_en", charge_en, 0);
        chk("rst_energy", energy_total, 0);
        chk("rst_bill_valid", bill_valid, 0);
        chk("rst_bill_amount", bill_amount, 0);
        chk("rst_bill_tag", bill_tag, 0);
        chk("rst_flags", {session_done, timeout_err, fault_flag}, 0);
        rst = 1'b0;
        step(1);

        // Normal session: auth after 3 cycles, 3 x 100 Wh, stop, bill.
        tariff = 16'd5; cs_id = CS; start_req = 1'b1;
        step(1);
        start_req = 1'b0;
        chk("n_auth_wait", state, 1);
        step(2);
        chk("n_still_wait", state, 1);
        chk("n_no_charge", charge_en, 0);
        auth_ok = 1'b1; session_key = KEY;
        step(1);
        chk("n_charging", state, 2);
        chk("n_charge_en", charge_en, 1);
        meter_valid = 1'b1; meter_wh = 16'd100;
        step(3);
        meter_valid = 1'b0;
        chk("n_energy", energy_total, 300);
        stop_req = 1'b1; bill_ready = 1'b1;
        step(1);
        stop_req = 1'b0;
        chk("n_stopping", state, 3);
        chk("n_charge_off", charge_en, 0);
        step(1);
        chk("n_billing", state, 4);
        chk("n_bill_valid", bill_valid, 1);
        chk("n_bill_amount", bill_amount, 1500);
        chk("n_bill_tag", bill_tag, KEY ^ CS ^ 64'd1500);
        chk("n_done_early", session_done, 0);
        step(1);
        chk("n_idle", state, 0);
        chk("n_done", session_done, 1);
        chk("n_valid_low", bill_valid, 0);
        step(1);
        chk("n_done_pulse", session_done, 0);
        chk("n_energy_hold", energy_total, 300);
        bill_ready = 1'b0; auth_ok = 1'b0;

        // Auth timeout: FAULT exactly AUTH_TO cycles after entering AUTH_WAIT.
        start_req = 1'b1;
        step(1);
        start_req = 1'b0;
        chk("t_energy_clr", energy_total, 0);
        step(AUTH_TO - 1);
        chk("t_pre_state", state, 1);
        chk("t_pre_tmo", timeout_err, 0);
        step(1);
        chk("t_fault", state, 5);
        chk("t_tmo", timeout_err, 1);
        chk("t_fault_flag", fault_flag, 1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk("t_clr_state", state, 0);
        chk("t_clr_tmo", timeout_err, 0);

        // Energy cap at 1000: 600 + 600 saturates and stops automatically.
        open_session(16'd2, 64'h1111);
        meter_valid = 1'b1; meter_wh = 16'd600;
        step(1);
        chk("c_first", energy_total, 600);
        chk("c_still_chg", state, 2);
        step(1);
        meter_valid = 1'b0;
        chk("c_sat", energy_total, 1000);
        chk("c_stopping", state, 3);
        chk("c_charge_off", charge_en, 0);
        step(1);
        chk("c_amount", bill_amount, 2000);
        chk("c_tag", bill_tag, KEY ^ 64'h1111 ^ 64'd2000);
        bill_ready = 1'b1;
        step(1);
        bill_ready = 1'b0;
        chk("c_idle", state, 0);

        // Auth drop with simultaneous sample and stop: FAULT, sample dropped.
        open_session(16'd3, 64'h2222);
        auth_ok = 1'b0; meter_valid = 1'b1; meter_wh = 16'd50; stop_req = 1'b1;
        step(1);
        meter_valid = 1'b0; stop_req = 1'b0;
        chk("a_fault", state, 5);
        chk("a_energy", energy_total, 0);
        chk("a_no_bill", bill_valid, 0);
        chk("a_tmo", timeout_err, 0);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk("a_clr", state, 0);

        // External fault beats stop and sample; fault_clr ignored while fault=1.
        open_session(16'd3, 64'h2222);
        fault = 1'b1; meter_valid = 1'b1; meter_wh = 16'd50; stop_req = 1'b1;
        step(1);
        meter_valid = 1'b0; stop_req = 1'b0;
        chk("f_fault", state, 5);
        chk("f_energy", energy_total, 0);
        chk("f_charge_off", charge_en, 0);
        fault_clr = 1'b1;
        step(1);
        chk("f_clr_ignored", state, 5);
        fault = 1'b0;
        step(1);
        fault_clr = 1'b0;
        chk("f_clr", state, 0);
        chk("f_flag_low", fault_flag, 0);

        // Bill back-pressure: 10 cycles of bill_ready low, start_req in between.
        open_session(16'd7, 64'h3333);
        meter_valid = 1'b1; meter_wh = 16'd10;
        step(1);
        meter_valid = 1'b0; stop_req = 1'b1;
        step(1);
        stop_req = 1'b0;
        step(1);
        for (int i = 0; i < 10; i++) begin
            start_req = (i == 3);
            step(1);
            chk("b_state", state, 4);
            chk("b_valid", bill_valid, 1);
            chk("b_amount", bill_amount, 70);
            chk("b_done_low", session_done, 0);
        end
        start_req = 1'b0;
        chk("b_tag", bill_tag, KEY ^ 64'h3333 ^ 64'd70);
        bill_ready = 1'b1;
        step(1);
        bill_ready = 1'b0;
        chk("b_idle", state, 0);
        chk("b_done", session_done, 1);

        // Meter watchdog: no samples after entering CHARGING.
        open_session(16'd1, 64'h4444);
        step(METER_TO - 1);
        chk("w_pre", state, 2);
        step(1);
`ifdef SESSION_WATCHDOG_EN
        chk("w_fault", state, 5);
        chk("w_tmo", timeout_err, 1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk("w_clr", state, 0);
        open_session(16'd1, 64'h4444);
`else
        chk("w_persist", state, 2);
        step(100);
        chk("w_persist_long", state, 2);
        chk("w_tmo_low", timeout_err, 0);
`endif

        // Asynchronous reset mid-session drops charge_en before the next edge.
        chk("r_pre_charge", charge_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("r_charge_off", charge_en, 0);
        chk("r_state", state, 0);
        step(1);
        rst = 1'b0;
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
